// File: rtl/ascon_bdi_sender.sv
// Host-side sender for the ASCON input channels: CFG, KEY, NONCE, AD, DATA, TAG, then an eoi pulse.
// Optional: define ASCON_KEY_REUSE_EN to add cmd_new_key_i and allow skipping the KEY segment.
module ascon_bdi_sender #(
  parameter int KEY_WORDS   = 4,
  parameter int NONCE_WORDS = 4,
  parameter int TAG_WORDS   = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_cfg_i,
  input  logic [7:0]  cmd_msg_len_i,
`ifdef ASCON_KEY_REUSE_EN
  input  logic        cmd_new_key_i,
`endif
  input  logic        src_valid_i,
  input  logic [31:0] src_data_i,
  output logic        src_ready_o,
  output logic        key_valid_o,
  output logic        key_last_o,
  output logic [31:0] key_o,
  input  logic        key_ready_i,
  output logic        bd_valid_o,
  output logic        bd_last_o,
  output logic [2:0]  bd_type_o,
  output logic [3:0]  bd_vld_byte_o,
  output logic [31:0] bd_o,
  input  logic        bdi_ready_i,
  output logic        eoi_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_KEY, S_NONCE, S_AD, S_DATA, S_TAG, S_EOI
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_cfg;
  logic [7:0]  r_msg_len;
  logic [7:0]  r_rem;
  logic [2:0]  r_wcnt;
  logic        w_xfer;
  logic        w_hash, w_dec, w_send_key;
  logic [7:0]  w_ad_size;
  state_t      w_to_tag, w_to_data, w_to_ad;

`ifdef ASCON_KEY_REUSE_EN
  logic r_new_key;
  assign w_send_key = r_new_key;
`else
  assign w_send_key = 1'b1;
`endif

  assign w_hash    = r_cfg[0];
  assign w_dec     = r_cfg[1];
  assign w_ad_size = r_cfg[23:16];

  // Successor chain that skips empty AD/DATA segments
  assign w_to_tag  = (w_dec && !w_hash) ? S_TAG : S_EOI;
  assign w_to_data = (r_msg_len != 8'd0) ? S_DATA : w_to_tag;
  assign w_to_ad   = (w_ad_size != 8'd0) ? S_AD : w_to_data;

  function automatic logic [3:0] f_mask(input logic [7:0] rem);
    if (rem >= 8'd4) return 4'hF;
    case (rem[1:0])
      2'd1:    return 4'h8;
      2'd2:    return 4'hC;
      2'd3:    return 4'hE;
      default: return 4'h0;
    endcase
  endfunction

  always_comb begin
    w_next        = r_state;
    w_xfer        = 1'b0;
    cmd_ready_o   = 1'b0;
    busy_o        = 1'b1;
    src_ready_o   = 1'b0;
    key_valid_o   = 1'b0;
    key_last_o    = 1'b0;
    key_o         = 32'h0;
    bd_valid_o    = 1'b0;
    bd_last_o     = 1'b0;
    bd_type_o     = 3'd0;
    bd_vld_byte_o = 4'h0;
    bd_o          = 32'h0;
    eoi_o         = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_valid_i) w_next = S_CFG;
      end
      S_CFG: begin
        bd_valid_o    = 1'b1;
        bd_last_o     = 1'b1;
        bd_vld_byte_o = 4'hF;
        bd_o          = r_cfg;
        if (bdi_ready_i) begin
          if (w_hash)          w_next = w_to_data;
          else if (w_send_key) w_next = S_KEY;
          else                 w_next = S_NONCE;
        end
      end
      S_KEY: begin
        key_valid_o = src_valid_i;
        key_o       = src_data_i;
        key_last_o  = (r_wcnt == 3'(KEY_WORDS - 1));
        src_ready_o = key_ready_i;
        w_xfer      = src_valid_i && key_ready_i;
        if (w_xfer && key_last_o) w_next = S_NONCE;
      end
      S_NONCE, S_AD, S_DATA, S_TAG: begin
        bd_valid_o  = src_valid_i;
        bd_o        = src_data_i;
        src_ready_o = bdi_ready_i;
        w_xfer      = src_valid_i && bdi_ready_i;
        case (r_state)
          S_NONCE: begin
            bd_type_o     = 3'd1;
            bd_vld_byte_o = 4'hF;
            bd_last_o     = (r_wcnt == 3'(NONCE_WORDS - 1));
            if (w_xfer && bd_last_o) w_next = w_to_ad;
          end
          S_AD: begin
            bd_type_o     = 3'd2;
            bd_vld_byte_o = f_mask(r_rem);
            bd_last_o     = (r_rem <= 8'd4);
            if (w_xfer && bd_last_o) w_next = w_to_data;
          end
          S_DATA: begin
            bd_type_o     = 3'd3;
            bd_vld_byte_o = f_mask(r_rem);
            bd_last_o     = (r_rem <= 8'd4);
            if (w_xfer && bd_last_o) w_next = w_to_tag;
          end
          default: begin
            bd_type_o     = 3'd4;
            bd_vld_byte_o = 4'hF;
            bd_last_o     = (r_wcnt == 3'(TAG_WORDS - 1));
            if (w_xfer && bd_last_o) w_next = S_EOI;
          end
        endcase
      end
      S_EOI: begin
        eoi_o  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_cfg     <= 32'h0;
      r_msg_len <= 8'h0;
      r_rem     <= 8'h0;
      r_wcnt    <= 3'd0;
`ifdef ASCON_KEY_REUSE_EN
      r_new_key <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && cmd_valid_i) begin
        r_cfg     <= cmd_cfg_i;
        r_msg_len <= cmd_msg_len_i;
`ifdef ASCON_KEY_REUSE_EN
        r_new_key <= cmd_new_key_i;
`endif
      end
      // Counters restart on every state change; rem is preloaded for byte-sized segments
      if (w_next != r_state) begin
        r_wcnt <= 3'd0;
        if (w_next == S_AD)        r_rem <= w_ad_size;
        else if (w_next == S_DATA) r_rem <= r_msg_len;
      end else if (w_xfer) begin
        r_wcnt <= r_wcnt + 3'd1;
        r_rem  <= (r_rem > 8'd4) ? (r_rem - 8'd4) : 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_ascon_bdi_sender.sv
// Directed bench for ascon_bdi_sender: a reference model queues expected beats, a monitor queues observed ones.
module tb_ascon_bdi_sender;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_cfg_i;
  logic [7:0]  cmd_msg_len_i;
`ifdef ASCON_KEY_REUSE_EN
  logic        cmd_new_key_i;
`endif
  logic        src_valid_i;
  logic [31:0] src_data_i;
  logic        src_ready_o;
  logic        key_valid_o, key_last_o;
  logic [31:0] key_o;
  logic        key_ready_i;
  logic        bd_valid_o, bd_last_o;
  logic [2:0]  bd_type_o;
  logic [3:0]  bd_vld_byte_o;
  logic [31:0] bd_o;
  logic        bdi_ready_i;
  logic        eoi_o, busy_o;

  always #5 clk_i = ~clk_i;

  ascon_bdi_sender dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_cfg_i(cmd_cfg_i), .cmd_msg_len_i(cmd_msg_len_i),
`ifdef ASCON_KEY_REUSE_EN
    .cmd_new_key_i(cmd_new_key_i),
`endif
    .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_ready_o(src_ready_o),
    .key_valid_o(key_valid_o), .key_last_o(key_last_o), .key_o(key_o), .key_ready_i(key_ready_i),
    .bd_valid_o(bd_valid_o), .bd_last_o(bd_last_o), .bd_type_o(bd_type_o),
    .bd_vld_byte_o(bd_vld_byte_o), .bd_o(bd_o), .bdi_ready_i(bdi_ready_i),
    .eoi_o(eoi_o), .busy_o(busy_o)
  );

  // ch: 0 = key beat, 1 = bd beat, 2 = eoi pulse
  typedef struct packed {
    logic [1:0]  ch;
    logic [2:0]  typ;
    logic        last;
    logic [3:0]  mask;
    logic [31:0] data;
  } beat_t;

  beat_t       expq[$];
  beat_t       obsq[$];
  int          obs_cyc[$];
  logic [31:0] srcq[$];

  int checks = 0, failures = 0;
  int pop_cnt = 0, sr_cnt = 0, both_cnt = 0, eoi_cnt = 0, key_cnt = 0;
  int cyc = 0;
  int m_idx = 0;
  logic [15:0] m_base;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic beat_t mk(input logic [1:0] ch, input logic [2:0] typ, input logic last,
                               input logic [3:0] mask, input logic [31:0] data);
    beat_t b;
    b.ch = ch; b.typ = typ; b.last = last; b.mask = mask; b.data = data;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Source feeder and output monitor: sample at negedge, advance source after posedge
  initial begin
    logic xfer;
    src_valid_i = 1'b0;
    src_data_i  = 32'h0;
    forever begin
      @(negedge clk_i);
      xfer = src_valid_i && src_ready_o;
      if (key_valid_o && bd_valid_o) both_cnt++;
      if (src_ready_o) sr_cnt++;
      if (key_valid_o) key_cnt++;
      if (key_valid_o && key_ready_i) begin
        obsq.push_back(mk(2'd0, 3'd0, key_last_o, 4'hF, key_o));
        obs_cyc.push_back(cyc);
      end
      if (bd_valid_o && bdi_ready_i) begin
        obsq.push_back(mk(2'd1, bd_type_o, bd_last_o, bd_vld_byte_o, bd_o));
        obs_cyc.push_back(cyc);
      end
      if (eoi_o) begin
        eoi_cnt++;
        obsq.push_back(mk(2'd2, 3'd0, 1'b0, 4'h0, 32'h0));
        obs_cyc.push_back(cyc);
      end
      @(posedge clk_i);
      #1;
      if (xfer && srcq.size() > 0) begin
        void'(srcq.pop_front());
        pop_cnt++;
      end
      src_valid_i = (srcq.size() > 0);
      src_data_i  = (srcq.size() > 0) ? srcq[0] : 32'h0;
    end
  end

  task automatic push_fixed(input logic [1:0] ch, input logic [2:0] typ, input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = {m_base, m_idx[15:0]};
      m_idx++;
      srcq.push_back(w);
      expq.push_back(mk(ch, typ, (i == n - 1), 4'hF, w));
    end
  endtask

  task automatic push_bytes(input logic [2:0] typ, input int nbytes);
    logic [31:0] w;
    logic [3:0]  mask;
    int rem;
    rem = nbytes;
    while (rem > 0) begin
      w = {m_base, m_idx[15:0]};
      m_idx++;
      if (rem >= 4)      mask = 4'hF;
      else if (rem == 3) mask = 4'hE;
      else if (rem == 2) mask = 4'hC;
      else               mask = 4'h8;
      srcq.push_back(w);
      expq.push_back(mk(2'd1, typ, (rem <= 4), mask, w));
      rem -= 4;
    end
  endtask

  // Reference model of one command: protocol order with empty AD/DATA skipped
  task automatic model_cmd(input logic [31:0] cfg, input logic [7:0] len, input logic nk,
                           input logic [15:0] base);
    m_idx  = 0;
    m_base = base;
    expq.push_back(mk(2'd1, 3'd0, 1'b1, 4'hF, cfg));
    if (!cfg[0]) begin
      if (nk) push_fixed(2'd0, 3'd0, 4);
      push_fixed(2'd1, 3'd1, 4);
      push_bytes(3'd2, int'(cfg[23:16]));
    end
    push_bytes(3'd3, int'(len));
    if (!cfg[0] && cfg[1]) push_fixed(2'd1, 3'd4, 4);
    expq.push_back(mk(2'd2, 3'd0, 1'b0, 4'h0, 32'h0));
  endtask

  task automatic do_cmd(input string tag, input logic [31:0] cfg, input logic [7:0] len,
                        input logic nk);
    bit acc;
    acc = 0;
    @(posedge clk_i);
    #1;
    cmd_valid_i   = 1'b1;
    cmd_cfg_i     = cfg;
    cmd_msg_len_i = len;
`ifdef ASCON_KEY_REUSE_EN
    cmd_new_key_i = nk;
`else
    if (nk !== 1'b1) $display("note: %s requests key reuse without the feature", tag);
`endif
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (cmd_ready_o) begin acc = 1; break; end
    end
    chk({tag, "_accept"}, 64'(acc), 64'd1);
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    chk({tag, "_busy_ready"}, {62'd0, busy_o, cmd_ready_o}, 64'b10);
  endtask

  task automatic wait_done(input string tag);
    int  start;
    bit  got;
    start = eoi_cnt;
    got   = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_i);
      if (eoi_cnt > start) begin got = 1; break; end
    end
    chk({tag, "_eoi_seen"}, 64'(got), 64'd1);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic compare_beats(input string tag);
    int n;
    chk({tag, "_beat_count"}, 64'(obsq.size()), 64'(expq.size()));
    n = (obsq.size() < expq.size()) ? obsq.size() : expq.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_beat%0d", tag, i), 64'(obsq[i]), 64'(expq[i]));
    obsq.delete();
    expq.delete();
    obs_cyc.delete();
  endtask

  initial begin
    int p0, s0, k0;
    logic [31:0] snap;
    bit found;
    rst_n_i       = 1'b0;
    cmd_valid_i   = 1'b0;
    cmd_cfg_i     = 32'h0;
    cmd_msg_len_i = 8'h0;
`ifdef ASCON_KEY_REUSE_EN
    cmd_new_key_i = 1'b0;
`endif
    key_ready_i   = 1'b1;
    bdi_ready_i   = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("reset_outputs",
        {56'd0, cmd_ready_o, busy_o, src_ready_o, key_valid_o, bd_valid_o, eoi_o, key_last_o, bd_last_o},
        {56'd0, 8'b1000_0000});
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    // Encrypt: ad=5, out=8, msg_len=8
    p0 = pop_cnt;
    model_cmd(32'h0005_0800, 8'd8, 1'b1, 16'hA1);
    do_cmd("enc", 32'h0005_0800, 8'd8, 1'b1);
    wait_done("enc");
    chk("enc_words_consumed", 64'(pop_cnt - p0), 64'd12);
    compare_beats("enc");
    chk("enc_idle", {62'd0, cmd_ready_o, busy_o}, 64'b10);

    // Decrypt: ad=0, msg_len=3
    p0 = pop_cnt;
    model_cmd(32'h0000_0302, 8'd3, 1'b1, 16'hB2);
    do_cmd("dec", 32'h0000_0302, 8'd3, 1'b1);
    wait_done("dec");
    chk("dec_words_consumed", 64'(pop_cnt - p0), 64'd13);
    compare_beats("dec");

    // Hash with empty message: CFG then eoi the following cycle
    s0 = sr_cnt;
    model_cmd(32'h0000_2001, 8'd0, 1'b1, 16'hC3);
    do_cmd("hash", 32'h0000_2001, 8'd0, 1'b1);
    wait_done("hash");
    chk("hash_src_ready_never", 64'(sr_cnt - s0), 64'd0);
    chk("hash_eoi_next_cycle",
        (obs_cyc.size() >= 2) ? 64'(obs_cyc[1] - obs_cyc[0]) : 64'hFFFF, 64'd1);
    compare_beats("hash");

    // Backpressure 1-0-0-1 during NONCE
    p0 = pop_cnt;
    model_cmd(32'h0005_0800, 8'd8, 1'b1, 16'hD4);
    do_cmd("bp", 32'h0005_0800, 8'd8, 1'b1);
    found = 0;
    for (int k = 0; k < 50; k++) begin
      if (bd_valid_o && bd_type_o == 3'd1) begin found = 1; break; end
      @(negedge clk_i);
    end
    chk("bp_nonce_reached", 64'(found), 64'd1);
    @(posedge clk_i);
    #1;
    bdi_ready_i = 1'b0;
    @(negedge clk_i);
    snap = bd_o;
    chk("bp_stall_word", {31'd0, bd_valid_o, snap}, {31'd0, 1'b1, 16'hD4, 16'd5});
    @(negedge clk_i);
    chk("bp_stall_stable", {31'd0, bd_valid_o, bd_o}, {31'd0, 1'b1, snap});
    chk("bp_stall_src_ready", 64'(src_ready_o), 64'd0);
    @(posedge clk_i);
    #1;
    bdi_ready_i = 1'b1;
    wait_done("bp");
    chk("bp_words_consumed", 64'(pop_cnt - p0), 64'd12);
    compare_beats("bp");

    // Reset in the middle of DATA, then a clean command
    model_cmd(32'h0000_0800, 8'd12, 1'b1, 16'hE5);
    do_cmd("rst", 32'h0000_0800, 8'd12, 1'b1);
    found = 0;
    for (int k = 0; k < 50; k++) begin
      if (bd_valid_o && bd_type_o == 3'd3) begin found = 1; break; end
      @(negedge clk_i);
    end
    chk("rst_data_reached", 64'(found), 64'd1);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("rst_async_outputs",
        {58'd0, cmd_ready_o, busy_o, src_ready_o, key_valid_o, bd_valid_o, eoi_o},
        {58'd0, 6'b100000});
    k0 = eoi_cnt;
    repeat (2) @(negedge clk_i);
    srcq.delete();
    obsq.delete();
    expq.delete();
    obs_cyc.delete();
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_no_eoi", 64'(eoi_cnt - k0), 64'd0);
    p0 = pop_cnt;
    model_cmd(32'h0000_0302, 8'd3, 1'b1, 16'hF6);
    do_cmd("post_rst", 32'h0000_0302, 8'd3, 1'b1);
    wait_done("post_rst");
    chk("post_rst_words", 64'(pop_cnt - p0), 64'd13);
    compare_beats("post_rst");

`ifdef ASCON_KEY_REUSE_EN
    // Key reuse: KEY segment skipped, NONCE directly after CFG
    k0 = key_cnt;
    model_cmd(32'h0000_0400, 8'd4, 1'b0, 16'h17);
    do_cmd("reuse", 32'h0000_0400, 8'd4, 1'b0);
    wait_done("reuse");
    chk("reuse_no_key_valid", 64'(key_cnt - k0), 64'd0);
    compare_beats("reuse");
`endif

    chk("key_bd_exclusive", 64'(both_cnt), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
